// File: rtl/regfile_pkg.sv
// Shared widths, constants and the writeback bundle type for the MIPS32 register file.
// Latency: none (declarations only); backpressure: n/a.
package regfile_pkg;

    localparam int REG_BUS      = 32;
    localparam int REG_ADDR_BUS = 5;
    localparam int REG_NUM      = 32;
    localparam int REG_NUM_LOG2 = 5;

    typedef logic [REG_BUS-1:0]      word_t;
    typedef logic [REG_ADDR_BUS-1:0] reg_addr_t;

    localparam word_t     ZERO_WORD     = '0;
    localparam logic      READ_ENABLE   = 1'b1;
    localparam logic      READ_DISABLE  = 1'b0;
    localparam logic      WRITE_ENABLE  = 1'b1;
    localparam logic      WRITE_DISABLE = 1'b0;
    localparam reg_addr_t NOP_REG_ADDR  = '0;

    // Writeback bundle as registered out of MEM/WB.
    typedef struct packed {
        logic      we;
        reg_addr_t waddr;
        word_t     wdata;
    } wb_t;

endpackage

// File: rtl/regfile_if.sv
// Writeback port plus two decode read ports of the register file.
// Latency: none (wiring only); backpressure: none, the register file always accepts.
interface regfile_if;
    import regfile_pkg::*;

    logic      we;
    reg_addr_t waddr;
    word_t     wdata;
    logic      re1;
    reg_addr_t raddr1;
    word_t     rdata1;
    logic      re2;
    reg_addr_t raddr2;
    word_t     rdata2;
    word_t     wr_count;

    modport master (
        output we, waddr, wdata,
        output re1, raddr1, re2, raddr2,
        input  rdata1, rdata2, wr_count
    );

    modport slave (
        input  we, waddr, wdata,
        input  re1, raddr1, re2, raddr2,
        output rdata1, rdata2, wr_count
    );

endinterface

// File: rtl/regfile_rport.sv
// One combinational read port: reset/$0 masking, optional write-first bypass (REGFILE_BYPASS_EN).
// Latency: zero cycles; backpressure: none.
module regfile_rport
    import regfile_pkg::*;
(
    input  logic                           rst,
    input  logic                           re,
    input  reg_addr_t                      raddr,
    input  wb_t                            wb,
    input  logic [REG_NUM-1:0][REG_BUS-1:0] regs,
    output word_t                          rdata
);

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic bypass_hit;

    // Without bypass the compare folds away and the port reads the pre-write value.
    assign bypass_hit = BYPASS && re && wb.we && (wb.waddr == raddr);

    always_comb begin
        rdata = ZERO_WORD;
        if (!rst) begin
            rdata = ZERO_WORD;
        end else if (raddr == NOP_REG_ADDR) begin
            rdata = ZERO_WORD;
        end else if (bypass_hit) begin
            rdata = wb.wdata;
        end else if (re == READ_ENABLE) begin
            rdata = regs[raddr];
        end
    end

endmodule

// File: rtl/regfile.sv
// 32x32 MIPS32 register file, $0 hardwired to zero, with committed-write counter; bypass via REGFILE_BYPASS_EN.
// Latency: write visible next cycle, reads combinational; backpressure: none.
module regfile
    import regfile_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    regfile_if.slave bus
);

    word_t                            regs_q [1:REG_NUM-1];
    logic [REG_NUM-1:0][REG_BUS-1:0] regs_rd;
    word_t                            wr_count_q;
    wb_t                              wb;

    assign wb.we    = bus.we;
    assign wb.waddr = bus.waddr;
    assign wb.wdata = bus.wdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < REG_NUM; i++) begin
                regs_q[i] <= ZERO_WORD;
            end
            wr_count_q <= ZERO_WORD;
        end else if (wb.we == WRITE_ENABLE && wb.waddr != NOP_REG_ADDR) begin
            regs_q[wb.waddr] <= wb.wdata;
            wr_count_q       <= wr_count_q + 32'd1;
        end
    end

    // Entry 0 is a constant so both ports can index the full array uniformly.
    always_comb begin
        regs_rd[0] = ZERO_WORD;
        for (int i = 1; i < REG_NUM; i++) begin
            regs_rd[i] = regs_q[i];
        end
    end

    regfile_rport u_rport1 (
        .rst   (rst),
        .re    (bus.re1),
        .raddr (bus.raddr1),
        .wb    (wb),
        .regs  (regs_rd),
        .rdata (bus.rdata1)
    );

    regfile_rport u_rport2 (
        .rst   (rst),
        .re    (bus.re2),
        .raddr (bus.raddr2),
        .wb    (wb),
        .regs  (regs_rd),
        .rdata (bus.rdata2)
    );

    assign bus.wr_count = wr_count_q;

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: expectations are queued by the stimulus and drained by a negedge monitor.
module tb_regfile;
    import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int SEL_RD1 = 0;
    localparam int SEL_RD2 = 1;
    localparam int SEL_CNT = 2;

    typedef struct {
        int    sel;
        word_t val;
    } exp_t;

    logic clk;
    logic rst;

    regfile_if rf_if ();

    regfile dut (
        .clk (clk),
        .rst (rst),
        .bus (rf_if)
    );

    exp_t  exp_q  [$];
    string name_q [$];
    int    n_vec;
    int    n_bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic expect_val(input int sel, input word_t val, input string name);
        exp_t e;
        e.sel = sel;
        e.val = val;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input reg_addr_t wa, input word_t wd,
                         input logic r1, input reg_addr_t a1,
                         input logic r2, input reg_addr_t a2);
        rf_if.we     = we;
        rf_if.waddr  = wa;
        rf_if.wdata  = wd;
        rf_if.re1    = r1;
        rf_if.raddr1 = a1;
        rf_if.re2    = r2;
        rf_if.raddr2 = a2;
    endtask

    // Monitor: outputs are combinational, so each negedge is a presentation point.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            word_t act;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            case (e.sel)
                SEL_RD1: act = rf_if.rdata1;
                SEL_RD2: act = rf_if.rdata2;
                default: act = rf_if.wr_count;
            endcase
            n_vec++;
            if (act !== e.val) begin
                n_bad++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, e.val);
            end
        end
    end

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst   = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
        #1;
        expect_val(SEL_RD1, 32'h0, "reset_rdata1");
        expect_val(SEL_RD2, 32'h0, "reset_rdata2");
        expect_val(SEL_CNT, 32'h0, "reset_wr_count");

        cyc();
        rst = 1'b1;
        drive(1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0);
        expect_val(SEL_CNT, 32'h0, "cnt_before_first_edge");

        cyc();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0, 5'd0);
        expect_val(SEL_RD1, 32'hDEADBEEF, "r7_read");
        expect_val(SEL_CNT, 32'd1, "cnt_after_r7");

        cyc();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd7);
        expect_val(SEL_RD1, 32'hDEADBEEF, "same_addr_port1");
        expect_val(SEL_RD2, 32'hDEADBEEF, "same_addr_port2");

        cyc();
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b0, 5'd0);
        expect_val(SEL_RD1, 32'h0, "r0_during_write");

        cyc();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b0, 5'd0);
        expect_val(SEL_RD1, 32'h0, "r0_after_write");
        expect_val(SEL_CNT, 32'd1, "cnt_r0_ignored");

        cyc();
        drive(1'b1, 5'd3, 32'h1, 1'b0, 5'd0, 1'b0, 5'd0);

        cyc();
        drive(1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b1, 5'd3);
        expect_val(SEL_RD2, BYP ? 32'hA5A5A5A5 : 32'h1, "rdw_same_cycle");
        expect_val(SEL_CNT, 32'd2, "cnt_after_r3");

        cyc();
        drive(1'b1, 5'd3, 32'h77, 1'b1, 5'd3, 1'b0, 5'd3);
        expect_val(SEL_RD2, 32'h0, "bypass_needs_re");
        expect_val(SEL_RD1, BYP ? 32'h77 : 32'hA5A5A5A5, "rdw_port1");
        expect_val(SEL_CNT, 32'd3, "cnt_after_a5");

        cyc();
        drive(1'b1, 5'd9, 32'h55, 1'b0, 5'd0, 1'b1, 5'd3);
        expect_val(SEL_RD2, 32'h77, "r3_next_cycle");
        expect_val(SEL_CNT, 32'd4, "cnt_after_77");

        cyc();
        drive(1'b1, 5'd5, 32'h12345678, 1'b0, 5'd9, 1'b1, 5'd9);
        expect_val(SEL_RD1, 32'h0, "re1_low");
        expect_val(SEL_RD2, 32'h55, "re2_high");
        expect_val(SEL_CNT, 32'd5, "cnt_after_r9");

        cyc();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd9);
        expect_val(SEL_RD1, 32'h12345678, "r5_read");
        expect_val(SEL_CNT, 32'd6, "cnt_after_r5");

        cyc();
        rst = 1'b0;
        drive(1'b1, 5'd10, 32'h00000BAD, 1'b1, 5'd5, 1'b1, 5'd10);
        expect_val(SEL_RD1, 32'h0, "rst_async_rdata1");
        expect_val(SEL_RD2, 32'h0, "rst_masks_bypass");
        expect_val(SEL_CNT, 32'h0, "rst_async_cnt");

        cyc();
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd10);
        expect_val(SEL_RD1, 32'h0, "r5_after_reset");
        expect_val(SEL_RD2, 32'h0, "write_in_reset_ignored");
        expect_val(SEL_CNT, 32'h0, "cnt_after_reset");

        cyc();
        force dut.wr_count_q = 32'hFFFFFFFF;
        #1;
        release dut.wr_count_q;
        expect_val(SEL_CNT, 32'hFFFFFFFF, "cnt_preload");

        cyc();
        drive(1'b1, 5'd1, 32'hCAFEF00D, 1'b0, 5'd0, 1'b0, 5'd0);
        expect_val(SEL_CNT, 32'hFFFFFFFF, "cnt_before_wrap");

        cyc();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b0, 5'd0);
        expect_val(SEL_RD1, 32'hCAFEF00D, "r1_read");
        expect_val(SEL_CNT, 32'h0, "cnt_wrap");

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
